// File: rtl/counter_v3_checker_pkg.sv
// Shared types and helpers for the counter_v3 checker family.
// Holds the checker state encoding, the default widths and a
// saturating increment usable by any counter width up to 32 bits.
package counter_v3_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      CHECK = 2'd2
   } chk_state_e;

   localparam int DEF_W   = 4;
   localparam int DEF_ECW = 8;

   // Adds one to a value that lives in a 'width'-bit register, sticking at
   // the all-ones value of that width instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
      logic [31:0] maxVal;
      maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= maxVal) ? maxVal : (value + 32'd1);
   endfunction

endpackage

// File: rtl/counter_v3_checker_model.sv
// Cycle-accurate reference model of the up/down loadable counter.
// Applies the counter's rules (reset, then load, then count up/down,
// else hold, all modulo 2^W) to the observed controls every edge.
// Shared by the counter checkers; it has no notion of checker state.
module counter_v3_model
   import counter_v3_chk_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_rst,
   input  logic         i_ce,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_up_down,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;
   logic [W-1:0] w_nextCnt;

   // Next value the real counter will show after this edge.
   always_comb begin
      w_nextCnt = r_cnt;
      if (i_rst) begin
         w_nextCnt = '0;
      end else if (i_load) begin
         w_nextCnt = i_load_val;
      end else if (i_ce) begin
         w_nextCnt = i_up_down ? (r_cnt + 1'b1) : (r_cnt - 1'b1);
      end
   end

   // Model register, cleared only by the checker's own reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_nextCnt;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/counter_v3_checker.sv
// Passive in-fabric checker for counter_v3.
// Tracks the counter with a reference model, compares it with the
// observed count every cycle once synchronised, and reports mismatches
// as a pulse, a sticky flag and a saturating count.
// Optional first-mismatch capture is built when CNT_CHK_FIRST_ERR_EN
// is defined; otherwise the capture ports read as zero.
module counter_v3_checker
   import counter_v3_chk_pkg::*;
#(
   parameter int W   = DEF_W,
   parameter int ECW = DEF_ECW
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_en,
   input  logic           i_obs_rst,
   input  logic           i_obs_ce,
   input  logic           i_obs_load,
   input  logic [W-1:0]   i_obs_load_val,
   input  logic           i_obs_up_down,
   input  logic [W-1:0]   i_obs_cnt,
   output logic           o_err,
   output logic           o_err_sticky,
   output logic [ECW-1:0] o_err_cnt,
   output logic [ECW-1:0] o_cmp_cnt,
   output logic [W-1:0]   o_exp_cnt,
   output logic [W-1:0]   o_first_err_exp,
   output logic [W-1:0]   o_first_err_got
);

   chk_state_e     r_state;
   chk_state_e     w_nextState;
   logic [W-1:0]   w_expCnt;
   logic           w_cmpEn;
   logic           w_arm;
   logic           w_mismatch;
   logic           r_err;
   logic           r_errSticky;
   logic [ECW-1:0] r_errCnt;
   logic [ECW-1:0] r_cmpCnt;

   counter_v3_model #(
      .W(W)
   ) uModel (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_rst      (i_obs_rst),
      .i_ce       (i_obs_ce),
      .i_load     (i_obs_load),
      .i_load_val (i_obs_load_val),
      .i_up_down  (i_obs_up_down),
      .o_cnt      (w_expCnt)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: disarming always wins, SYNC waits for a known counter value.
   always_comb begin
      w_nextState = r_state;
      if (!i_en) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_nextState = SYNC;
            SYNC:    if (i_obs_rst || i_obs_load) w_nextState = CHECK;
            CHECK:   w_nextState = CHECK;
            default: w_nextState = IDLE;
         endcase
      end
   end

   // Per-edge decode: arming pulse, compare enable and the compare result.
   always_comb begin
      w_arm      = i_en && (r_state == IDLE);
      w_cmpEn    = i_en && (r_state == CHECK);
      w_mismatch = w_cmpEn && (i_obs_cnt != w_expCnt);
   end

   // Error pulse, sticky flag and saturating statistics counters.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_err       <= 1'b0;
         r_errSticky <= 1'b0;
         r_errCnt    <= '0;
         r_cmpCnt    <= '0;
      end else if (!i_en) begin
         r_err       <= 1'b0;
         r_errSticky <= 1'b0;
      end else if (w_arm) begin
         r_err       <= 1'b0;
         r_errCnt    <= '0;
         r_cmpCnt    <= '0;
      end else begin
         r_err <= w_mismatch;
         if (w_mismatch) begin
            r_errSticky <= 1'b1;
            r_errCnt    <= ECW'(sat_inc(32'(r_errCnt), ECW));
         end
         if (w_cmpEn) begin
            r_cmpCnt <= ECW'(sat_inc(32'(r_cmpCnt), ECW));
         end
      end
   end

`ifdef CNT_CHK_FIRST_ERR_EN
   logic [W-1:0] r_firstErrExp;
   logic [W-1:0] r_firstErrGot;

   // Snapshot of the first mismatch since arming; the sticky flag marks "already taken".
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_firstErrExp <= '0;
         r_firstErrGot <= '0;
      end else if (w_arm) begin
         r_firstErrExp <= '0;
         r_firstErrGot <= '0;
      end else if (w_mismatch && !r_errSticky) begin
         r_firstErrExp <= w_expCnt;
         r_firstErrGot <= i_obs_cnt;
      end
   end

   assign o_first_err_exp = r_firstErrExp;
   assign o_first_err_got = r_firstErrGot;
`else
   assign o_first_err_exp = '0;
   assign o_first_err_got = '0;
`endif

   assign o_err        = r_err;
   assign o_err_sticky = r_errSticky;
   assign o_err_cnt    = r_errCnt;
   assign o_cmp_cnt    = r_cmpCnt;
   assign o_exp_cnt    = w_expCnt;

endmodule

// File: tb/tb_counter_v3_checker.sv
// Self-checking bench for counter_v3_checker (W=4, ECW=8).
// A behavioural counter drives the observed signals (optionally corrupted)
// and a behavioural checker model predicts every output each cycle.
// Directed phases pin the model with literal values; a random phase follows.
module tb_counter_v3_checker;

   localparam int W   = 4;
   localparam int ECW = 8;

   logic           clock = 1'b0;
   logic           rstN = 1'b0;
   logic           en = 1'b0;
   logic           obsRst = 1'b0;
   logic           obsCe = 1'b0;
   logic           obsLoad = 1'b0;
   logic [W-1:0]   obsLoadVal = '0;
   logic           obsUpDown = 1'b0;
   logic [W-1:0]   obsCnt = '0;
   logic           err;
   logic           errSticky;
   logic [ECW-1:0] errCnt;
   logic [ECW-1:0] cmpCnt;
   logic [W-1:0]   expCnt;
   logic [W-1:0]   firstErrExp;
   logic [W-1:0]   firstErrGot;

   int testsRun = 0;
   int testsFailed = 0;

   // Behavioural counter being observed, and the expected checker view.
   logic [W-1:0] realCnt = 4'd9;
   bit   mArmed = 0;
   bit   mSynced = 0;
   bit   mErr = 0;
   bit   mSticky = 0;
   int   mErrCnt = 0;
   int   mCmpCnt = 0;
   logic [W-1:0] mExp = '0;
   logic [W-1:0] mFirstExp = '0;
   logic [W-1:0] mFirstGot = '0;

   counter_v3_checker #(
      .W(W),
      .ECW(ECW)
   ) dut (
      .i_clk          (clock),
      .i_rst_n        (rstN),
      .i_en           (en),
      .i_obs_rst      (obsRst),
      .i_obs_ce       (obsCe),
      .i_obs_load     (obsLoad),
      .i_obs_load_val (obsLoadVal),
      .i_obs_up_down  (obsUpDown),
      .i_obs_cnt      (obsCnt),
      .o_err          (err),
      .o_err_sticky   (errSticky),
      .o_err_cnt      (errCnt),
      .o_cmp_cnt      (cmpCnt),
      .o_exp_cnt      (expCnt),
      .o_first_err_exp(firstErrExp),
      .o_first_err_got(firstErrGot)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   function automatic logic [W-1:0] nextValue(input logic [W-1:0] cur, input bit rst,
                                              input bit load, input logic [W-1:0] val,
                                              input bit ce, input bit up);
      int v;
      if (rst) v = 0;
      else if (load) v = int'(val);
      else if (ce) v = up ? (int'(cur) + 1) % 16 : (int'(cur) + 15) % 16;
      else v = int'(cur);
      return v[W-1:0];
   endfunction

   function automatic int satAdd(input int v);
      return (v + 1 > 255) ? 255 : v + 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: apply the checker's rules to what it saw at this edge.
   always @(posedge clock) begin
      if (!rstN) begin
         mArmed = 0; mSynced = 0; mErr = 0; mSticky = 0;
         mErrCnt = 0; mCmpCnt = 0; mExp = '0; mFirstExp = '0; mFirstGot = '0;
      end else begin
         if (!en) begin
            mArmed = 0; mSynced = 0; mErr = 0; mSticky = 0;
         end else if (!mArmed) begin
            mArmed = 1; mSynced = 0; mErr = 0; mErrCnt = 0; mCmpCnt = 0;
            mFirstExp = '0; mFirstGot = '0;
         end else if (!mSynced) begin
            mErr = 0;
            if (obsRst || obsLoad) mSynced = 1;
         end else begin
            mErr = (obsCnt != mExp);
            if (mErr) begin
               if (!mSticky) begin
                  mFirstExp = mExp;
                  mFirstGot = obsCnt;
               end
               mSticky = 1;
               mErrCnt = satAdd(mErrCnt);
            end
            mCmpCnt = satAdd(mCmpCnt);
         end
         mExp = nextValue(mExp, obsRst, obsLoad, obsLoadVal, obsCe, obsUpDown);
      end
      realCnt = nextValue(realCnt, obsRst, obsLoad, obsLoadVal, obsCe, obsUpDown);
   end

   // Compare process: every cycle, just after the edge.
   always @(posedge clock) begin
      #1;
      checkOutput("err", 32'(err), 32'(mErr));
      checkOutput("err_sticky", 32'(errSticky), 32'(mSticky));
      checkOutput("err_cnt", 32'(errCnt), 32'(mErrCnt));
      checkOutput("cmp_cnt", 32'(cmpCnt), 32'(mCmpCnt));
      if (mSynced) checkOutput("exp_cnt", 32'(expCnt), 32'(mExp));
`ifdef CNT_CHK_FIRST_ERR_EN
      checkOutput("first_err_exp", 32'(firstErrExp), 32'(mFirstExp));
      checkOutput("first_err_got", 32'(firstErrGot), 32'(mFirstGot));
`else
      checkOutput("first_err_exp", 32'(firstErrExp), 32'd0);
      checkOutput("first_err_got", 32'(firstErrGot), 32'd0);
`endif
   end

   // Drive one cycle of controls at the falling edge, return just after the next rising edge.
   task automatic applyStimulus(input bit rstNv, input bit enV, input bit rstV, input bit loadV,
                                input logic [W-1:0] valV, input bit ceV, input bit upV,
                                input logic [W-1:0] mask);
      @(negedge clock);
      rstN = rstNv;
      en = enV;
      obsRst = rstV;
      obsLoad = loadV;
      obsLoadVal = valV;
      obsCe = ceV;
      obsUpDown = upV;
      obsCnt = realCnt ^ mask;
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Checker reset.
      applyStimulus(0, 0, 0, 0, 4'd0, 0, 0, 4'd0);
      applyStimulus(0, 0, 0, 0, 4'd0, 0, 0, 4'd0);
      checkOutput("lit reset err_cnt", 32'(errCnt), 32'd0);
      checkOutput("lit reset cmp_cnt", 32'(cmpCnt), 32'd0);
      checkOutput("lit reset exp_cnt", 32'(expCnt), 32'd0);
      checkOutput("lit reset err", 32'(err), 32'd0);

      // Arm, synchronise on obs_rst, count up through the wrap.
      applyStimulus(1, 1, 0, 0, 4'd0, 0, 0, 4'd0);
      applyStimulus(1, 1, 1, 0, 4'd0, 0, 0, 4'd0);
      for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 0, 4'd0, 1, 1, 4'd0);
      checkOutput("lit up20 cmp_cnt", 32'(cmpCnt), 32'd20);
      checkOutput("lit up20 err_cnt", 32'(errCnt), 32'd0);
      checkOutput("lit up20 exp_cnt", 32'(expCnt), 32'd4);

      // Load 0xC with ce low, then count down.
      applyStimulus(1, 1, 0, 1, 4'hC, 0, 0, 4'd0);
      checkOutput("lit load exp_cnt", 32'(expCnt), 32'd12);
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 4'd0, 1, 0, 4'd0);
      checkOutput("lit down exp_cnt", 32'(expCnt), 32'd9);
      checkOutput("lit down cmp_cnt", 32'(cmpCnt), 32'd24);
      for (int i = 0; i < 2; i++) applyStimulus(1, 1, 0, 0, 4'd0, 1, 0, 4'd0);

      // Expected 7, observed 5.
      applyStimulus(1, 1, 0, 0, 4'd0, 0, 0, 4'd2);
      checkOutput("lit mis err", 32'(err), 32'd1);
      checkOutput("lit mis sticky", 32'(errSticky), 32'd1);
      checkOutput("lit mis err_cnt", 32'(errCnt), 32'd1);
`ifdef CNT_CHK_FIRST_ERR_EN
      checkOutput("lit first exp", 32'(firstErrExp), 32'd7);
      checkOutput("lit first got", 32'(firstErrGot), 32'd5);
`endif
      applyStimulus(1, 1, 0, 0, 4'd0, 0, 0, 4'd0);
      checkOutput("lit pulse err", 32'(err), 32'd0);
      checkOutput("lit pulse sticky", 32'(errSticky), 32'd1);

      // Hold ce low for 10 cycles with a stable counter.
      for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0, 4'd0, 0, 0, 4'd0);
      checkOutput("lit hold exp_cnt", 32'(expCnt), 32'd7);
      checkOutput("lit hold cmp_cnt", 32'(cmpCnt), 32'd38);
      checkOutput("lit hold err_cnt", 32'(errCnt), 32'd1);

      // 300 consecutive mismatches saturate both counters.
      for (int i = 0; i < 300; i++) applyStimulus(1, 1, 0, 0, 4'd0, 0, 0, 4'd8);
      checkOutput("lit sat err_cnt", 32'(errCnt), 32'd255);
      checkOutput("lit sat cmp_cnt", 32'(cmpCnt), 32'd255);

      // Disarm, then re-arm without a sync event.
      applyStimulus(1, 0, 0, 0, 4'd0, 0, 0, 4'd0);
      checkOutput("lit dis sticky", 32'(errSticky), 32'd0);
      checkOutput("lit dis err_cnt", 32'(errCnt), 32'd255);
      for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 4'd0, 1, 1, 4'd0);
      checkOutput("lit rearm cmp_cnt", 32'(cmpCnt), 32'd0);
      checkOutput("lit rearm err_cnt", 32'(errCnt), 32'd0);
      checkOutput("lit rearm err", 32'(err), 32'd0);
      applyStimulus(1, 1, 0, 1, 4'd3, 0, 0, 4'd0);
      checkOutput("lit sync3 exp_cnt", 32'(expCnt), 32'd3);
      applyStimulus(1, 1, 0, 0, 4'd0, 0, 0, 4'd0);
      checkOutput("lit sync3 cmp_cnt", 32'(cmpCnt), 32'd1);

      // Checker reset in the middle of checking.
      applyStimulus(1, 1, 0, 0, 4'd0, 0, 0, 4'd1);
      applyStimulus(0, 1, 0, 0, 4'd0, 1, 1, 4'd0);
      checkOutput("lit midrst err", 32'(err), 32'd0);
      checkOutput("lit midrst err_cnt", 32'(errCnt), 32'd0);
      checkOutput("lit midrst cmp_cnt", 32'(cmpCnt), 32'd0);

      // Random phase against the behavioural model.
      for (int i = 0; i < 3000; i++) begin
         bit rstNv, enV, rstV, loadV, ceV, upV;
         logic [W-1:0] valV, maskV;
         rstNv = ($urandom_range(0, 199) != 0);
         enV   = ($urandom_range(0, 59) != 0);
         rstV  = ($urandom_range(0, 15) == 0);
         loadV = ($urandom_range(0, 7) == 0);
         ceV   = $urandom_range(0, 1) == 1;
         upV   = $urandom_range(0, 1) == 1;
         valV  = 4'($urandom_range(0, 15));
         maskV = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         applyStimulus(rstNv, enV, rstV, loadV, valV, ceV, upV, maskV);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
